// File: rtl/lc4_pipe_pkg.sv
// Shared types for the LC4 pipeline sequencing logic: shadow-stage entries,
// the multi-cycle FSM states and the register-match helper.
package lc4_pipe_pkg;

  typedef struct packed {
    logic       valid;
    logic [2:0] wsel;
    logic       we;
    logic       nzp_we;
    logic       is_load;
  } shadow_entry_t;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  localparam shadow_entry_t NOP_ENTRY = '0;

  // True when an enabled source read names the given destination register.
  function automatic logic src_match(input logic re, input logic [2:0] sel,
                                     input logic [2:0] wsel);
    return re & (sel == wsel);
  endfunction

endpackage

// File: rtl/lc4_mc_counter.sv
// IDLE/BUSY sequencer for DIV/MOD occupancy of the X-stage ALU.
// busy_o is high for DIV_LAT-1 cycles after start_o is accepted.
module lc4_mc_counter
  import lc4_pipe_pkg::*;
#(
  parameter int DIV_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic busy_o,
  output logic last_o
);

  mc_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;

  // State and down-counter; a single-cycle latency never enters BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MC_IDLE: begin
          if (start_i && (DIV_LAT > 1)) begin
            state_q <= MC_BUSY;
            cnt_q   <= CNT_W'(DIV_LAT - 1);
          end else begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
          end
        end
        MC_BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
          end else begin
            state_q <= MC_BUSY;
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= MC_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o = (state_q == MC_BUSY);
  assign last_o = (state_q == MC_BUSY) && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lc4_hazard_ctrl.sv
// LC4 five-stage sequencing controller: load-use, redirect flush and DIV/MOD
// occupancy, driven by a shadow X/M/W scoreboard of destination info.
module lc4_hazard_ctrl
  import lc4_pipe_pkg::*;
#(
  parameter int DIV_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_valid,
  input  logic [2:0] d_r1sel,
  input  logic       d_r1re,
  input  logic [2:0] d_r2sel,
  input  logic       d_r2re,
  input  logic [2:0] d_wsel,
  input  logic       d_regfile_we,
  input  logic       d_nzp_we,
  input  logic       d_is_load,
  input  logic       d_is_store,
  input  logic       d_is_branch,
  input  logic       d_is_multicycle,
  input  logic       x_redirect,
  output logic       stall_fd,
  output logic       bubble_x,
  output logic       flush_fd,
  output logic       x_hold,
  output logic       mc_busy,
  output logic       x_valid,
  output logic       m_valid,
  output logic       w_valid
);

  shadow_entry_t x_q, m_q, w_q;
  shadow_entry_t x_d, m_d, w_d;
  shadow_entry_t d_ent_s;
  logic lu_s, flush_s, stall_s, bubble_s, mc_start_s;
  logic mc_busy_s, mc_last_s;
  logic unused_sink_s;

  lc4_mc_counter #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_mc (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mc_start_s),
    .busy_o  (mc_busy_s),
    .last_o  (mc_last_s)
  );

  // Hazard detection, pipeline controls and next shadow contents.
  always_comb begin
    d_ent_s = NOP_ENTRY;
    d_ent_s.valid   = d_valid;
    d_ent_s.wsel    = d_wsel;
    d_ent_s.we      = d_regfile_we;
    d_ent_s.nzp_we  = d_nzp_we;
    d_ent_s.is_load = d_is_load;

    // Store data is bypassed from W to M, so rt of a store never stalls.
    if (x_q.valid && x_q.is_load && d_valid) begin
      lu_s = (x_q.we && (src_match(d_r1re, d_r1sel, x_q.wsel) ||
                         src_match(d_r2re & ~d_is_store, d_r2sel, x_q.wsel)))
             || d_is_branch;
    end else begin
      lu_s = 1'b0;
    end

    flush_s    = x_redirect & x_q.valid & ~mc_busy_s;
    stall_s    = ~flush_s & (lu_s | mc_busy_s);
    bubble_s   = ~mc_busy_s & (flush_s | lu_s);
    mc_start_s = d_valid & d_is_multicycle & ~mc_busy_s & ~bubble_s;

    w_d = m_q;
    if (mc_busy_s) begin
      m_d = NOP_ENTRY;
      x_d = x_q;
    end else if (bubble_s) begin
      m_d = x_q;
      x_d = NOP_ENTRY;
    end else begin
      m_d = x_q;
      x_d = d_ent_s;
    end
  end

  // Shadow X/M/W scoreboard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= NOP_ENTRY;
      m_q <= NOP_ENTRY;
      w_q <= NOP_ENTRY;
    end else begin
      x_q <= x_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign stall_fd = stall_s;
  assign bubble_x = bubble_s;
  assign flush_fd = flush_s;
  assign x_hold   = mc_busy_s;
  assign mc_busy  = mc_busy_s;
  assign x_valid  = x_q.valid;
  assign m_valid  = m_q.valid;
  assign w_valid  = w_q.valid;

  // W destination info and the counter's last flag are kept for tracing only.
  assign unused_sink_s = ^{mc_last_s, w_q};

endmodule

// File: tb/tb_lc4_hazard_ctrl.sv
// Self-checking bench for lc4_hazard_ctrl: directed test-plan scenarios with
// literal expectations, then randomized traffic against a stage-level model.
module tb_lc4_hazard_ctrl;

  localparam int DIV_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic d_valid, d_r1re, d_r2re, d_regfile_we, d_nzp_we;
  logic d_is_load, d_is_store, d_is_branch, d_is_multicycle, x_redirect;
  logic [2:0] d_r1sel, d_r2sel, d_wsel;
  logic stall_fd, bubble_x, flush_fd, x_hold, mc_busy, x_valid, m_valid, w_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lc4_hazard_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_r1sel(d_r1sel), .d_r1re(d_r1re), .d_r2sel(d_r2sel), .d_r2re(d_r2re),
    .d_wsel(d_wsel), .d_regfile_we(d_regfile_we), .d_nzp_we(d_nzp_we),
    .d_is_load(d_is_load), .d_is_store(d_is_store), .d_is_branch(d_is_branch),
    .d_is_multicycle(d_is_multicycle), .x_redirect(x_redirect),
    .stall_fd(stall_fd), .bubble_x(bubble_x), .flush_fd(flush_fd),
    .x_hold(x_hold), .mc_busy(mc_busy), .x_valid(x_valid), .m_valid(m_valid),
    .w_valid(w_valid)
  );

  // Model: one record per stage, plus how many cycles X's occupant has spent there.
  typedef struct packed {
    bit v; bit [2:0] ws; bit we; bit ld; bit mc;
  } ent_t;

  ent_t sx, sm, sw, nx, nm, nw;
  int   x_age, n_age;
  bit   e_busy, e_lu, e_flush, e_stall, e_bubble;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    return sx.v && sx.mc && (x_age < DIV_LAT);
  endfunction

  // Evaluate the model for the current inputs, compare every output, and
  // prepare the model's next stage contents.
  task automatic ev();
    ent_t dent;
    #1;
    e_busy = model_busy();
    e_lu = 1'b0;
    if (sx.v && sx.ld && d_valid) begin
      if (sx.we && d_r1re && d_r1sel == sx.ws) e_lu = 1'b1;
      if (sx.we && d_r2re && !d_is_store && d_r2sel == sx.ws) e_lu = 1'b1;
      if (d_is_branch) e_lu = 1'b1;
    end
    e_flush  = x_redirect && sx.v && !e_busy;
    e_stall  = !e_flush && (e_lu || e_busy);
    e_bubble = !e_busy && (e_flush || e_lu);

    chk("stall_fd", stall_fd, e_stall);
    chk("bubble_x", bubble_x, e_bubble);
    chk("flush_fd", flush_fd, e_flush);
    chk("x_hold",   x_hold,   e_busy);
    chk("mc_busy",  mc_busy,  e_busy);
    chk("x_valid",  x_valid,  sx.v);
    chk("m_valid",  m_valid,  sm.v);
    chk("w_valid",  w_valid,  sw.v);
    checks++;
    assert (!(x_redirect && mc_busy)) else begin
      errors++;
      $display("FAIL redirect_while_busy: x_redirect=%0d mc_busy=%0d", x_redirect, mc_busy);
    end

    dent = '{v: d_valid, ws: d_wsel, we: d_regfile_we, ld: d_is_load,
             mc: d_valid && d_is_multicycle};
    if (!rst_n) begin
      nx = '0; nm = '0; nw = '0; n_age = 0;
    end else begin
      nw = sm;
      if (e_busy) begin
        nm = '0; nx = sx; n_age = x_age + 1;
      end else begin
        nm = sx; nx = e_bubble ? ent_t'('0) : dent; n_age = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    sx = nx; sm = nm; sw = nw; x_age = n_age;
    @(negedge clk);
  endtask

  task automatic set_d(input bit v, input int r1, input bit r1re, input int r2,
                       input bit r2re, input int w, input bit we, input bit ld,
                       input bit st, input bit br, input bit mc);
    d_valid = v; d_r1sel = 3'(r1); d_r1re = r1re; d_r2sel = 3'(r2); d_r2re = r2re;
    d_wsel = 3'(w); d_regfile_we = we; d_nzp_we = we; d_is_load = ld;
    d_is_store = st; d_is_branch = br; d_is_multicycle = mc; x_redirect = 1'b0;
  endtask

  task automatic nop();             set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ldr(int w, int b); set_d(1, b, 1, 0, 0, w, 1, 1, 0, 0, 0); endtask
  task automatic add(int w, int a, int b); set_d(1, a, 1, b, 1, w, 1, 0, 0, 0, 0); endtask
  task automatic str(int t, int b); set_d(1, b, 1, t, 1, 0, 0, 0, 1, 0, 0); endtask
  task automatic br();              set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic div(int w, int a, int b); set_d(1, a, 1, b, 1, w, 1, 0, 0, 0, 1); endtask

  initial begin
    int kind;
    nop();
    rst_n = 1'b0;
    sx = '0; sm = '0; sw = '0; x_age = 0;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    ev(); tick();
    rst_n = 1'b1;
    ev();
    chk("rst_mc_busy", mc_busy, 0); chk("rst_x_valid", x_valid, 0);
    chk("rst_stall", stall_fd, 0);  chk("rst_m_valid", m_valid, 0);
    tick();

    // Load-use on rs
    ldr(3, 6); ev(); tick();
    add(1, 3, 4); ev();
    chk("lu_stall", stall_fd, 1); chk("lu_bubble", bubble_x, 1);
    tick();
    ev(); chk("lu_after_xv", x_valid, 0); chk("lu_after_stall", stall_fd, 0);
    tick();
    nop(); ev(); chk("lu_add_in_x", x_valid, 1); tick();

    // Store data exemption
    ldr(2, 6); ev(); tick();
    str(2, 5); ev(); chk("st_rt_nostall", stall_fd, 0);
    d_r1sel = 3'd2; ev(); chk("st_rs_stall", stall_fd, 1);
    tick();
    nop(); ev(); tick();

    // Branch after load, and after an ALU op
    ldr(4, 6); ev(); tick();
    br(); ev(); chk("br_load_stall", stall_fd, 1); tick();
    ev(); chk("br_released", stall_fd, 0); tick();
    add(5, 1, 2); ev(); tick();
    br(); ev(); chk("br_alu_nostall", stall_fd, 0); tick();
    nop(); ev(); tick(); ev(); tick(); ev(); tick();

    // Multi-cycle occupancy
    div(1, 2, 3); ev(); chk("div_enter_busy", mc_busy, 0); tick();
    nop();
    for (int k = 0; k < DIV_LAT - 1; k++) begin
      ev();
      chk("div_busy", mc_busy, 1); chk("div_hold", x_hold, 1);
      chk("div_stall", stall_fd, 1); chk("div_m_bubble", m_valid, 0);
      tick();
    end
    ev(); chk("div_done", mc_busy, 0); chk("div_still_x", x_valid, 1);
    chk("div_done_stall", stall_fd, 0); tick();
    ev(); chk("div_in_m", m_valid, 1); tick();

    // Redirect beats load-use
    ldr(3, 6); ev(); tick();
    add(1, 3, 3); x_redirect = 1'b1; ev();
    chk("rd_flush", flush_fd, 1); chk("rd_bubble", bubble_x, 1);
    chk("rd_nostall", stall_fd, 0); tick();
    nop(); ev(); chk("rd_x_killed", x_valid, 0); tick();

    // Reset in the middle of BUSY
    div(2, 1, 1); ev(); tick();
    nop(); ev(); tick();
    rst_n = 1'b0; ev(); tick();
    rst_n = 1'b1; ev();
    chk("mrst_busy", mc_busy, 0); chk("mrst_xv", x_valid, 0);
    chk("mrst_mv", m_valid, 0);   chk("mrst_wv", w_valid, 0);
    tick();
    div(2, 1, 1); ev(); tick();
    nop();
    for (int k = 0; k < DIV_LAT - 1; k++) begin
      ev(); chk("mrst_div_busy", mc_busy, 1); tick();
    end
    ev(); chk("mrst_div_done", mc_busy, 0); tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1: ldr($urandom_range(0, 3), $urandom_range(0, 3));
        2: str($urandom_range(0, 3), $urandom_range(0, 3));
        3: br();
        4: div($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        default: add($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 9) == 0) d_valid = 1'b0;
      d_r1re = d_r1re & ($urandom_range(0, 3) != 0);
      d_r2re = d_r2re & ($urandom_range(0, 3) != 0);
      x_redirect = !model_busy() && ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 59) != 0);
      ev(); tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
